// File: rtl/cpu_dmem_arb_pkg.sv
// Shared types and defaults for the CPU data-memory arbiter.
package cpu_dmem_arb_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_CPU,
        OWNER_AUX
    } dmem_owner_t;

    localparam int unsigned DMEM_ARB_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/cpu_dmem_starve_ctr.sv
// Counts consecutive refused auxiliary cycles and raises force_o once the
// limit is reached; both clear on the next auxiliary handshake.
module cpu_dmem_starve_ctr
    import cpu_dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DMEM_ARB_LIMIT_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic aux_valid_i,
    input  logic aux_ready_i,
    output logic force_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] wait_q, wait_d;
    logic       force_q, force_d;

    always_comb begin
        wait_d  = wait_q;
        force_d = force_q;
        if (aux_valid_i && aux_ready_i) begin
            wait_d  = '0;
            force_d = 1'b0;
        end else begin
            if (aux_valid_i && (wait_q != LIMIT)) begin
                wait_d = wait_q + 8'd1;
            end
            if (wait_d == LIMIT) begin
                force_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wait_q  <= '0;
            force_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            force_q <= force_d;
        end
    end

    assign force_o = force_q;

endmodule

// File: rtl/cpu_dmem_arb.sv
// Data-memory port arbiter: CPU fixed priority, auxiliary master with
// one-cycle read return. Starvation guard enabled by CPU_DMEM_ARB_STARVE_EN.
module cpu_dmem_arb
    import cpu_dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DMEM_ARB_LIMIT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] cpu_addr_i,
    input  logic        cpu_read_enable_i,
    input  logic [31:0] cpu_write_data_i,
    input  logic [3:0]  cpu_write_mask_i,
    output logic        cpu_stall_o,
    input  logic        aux_valid_i,
    output logic        aux_ready_o,
    input  logic [31:0] aux_addr_i,
    input  logic        aux_write_i,
    input  logic [31:0] aux_write_data_i,
    input  logic [3:0]  aux_write_mask_i,
    output logic [31:0] aux_rdata_o,
    output logic        aux_rvalid_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_read_enable_o,
    output logic [31:0] mem_write_data_o,
    output logic [3:0]  mem_write_mask_o,
    input  logic [31:0] mem_read_data_i
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_limit_check
        $error("cpu_dmem_arb: STARVE_LIMIT must be in 1..255");
    end

    logic        cpu_req;
    logic        aux_force;
    logic        aux_hs;
    logic        aux_rvalid_q, aux_rvalid_d;
    word_t       aux_addr_w;
    dmem_owner_t owner;

    assign cpu_req    = cpu_read_enable_i | (|cpu_write_mask_i);
    assign aux_addr_w = aux_addr_i & ~word_t'(3);

`ifdef CPU_DMEM_ARB_STARVE_EN
    cpu_dmem_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .aux_valid_i(aux_valid_i),
        .aux_ready_i(aux_ready_o),
        .force_o    (aux_force)
    );
`else
    assign aux_force = 1'b0;
`endif

    // Owner is gated by reset so every output reads idle while reset is held.
    always_comb begin
        owner = OWNER_NONE;
        if (!reset_ni) begin
            owner = OWNER_NONE;
        end else if (aux_force && aux_valid_i) begin
            owner = OWNER_AUX;
        end else if (cpu_req) begin
            owner = OWNER_CPU;
        end else if (aux_valid_i) begin
            owner = OWNER_AUX;
        end
    end

    always_comb begin
        mem_addr_o        = '0;
        mem_read_enable_o = 1'b0;
        mem_write_data_o  = '0;
        mem_write_mask_o  = '0;
        aux_ready_o       = 1'b0;
        cpu_stall_o       = 1'b0;
        case (owner)
            OWNER_CPU: begin
                mem_addr_o        = cpu_addr_i;
                mem_read_enable_o = cpu_read_enable_i;
                mem_write_data_o  = cpu_write_data_i;
                mem_write_mask_o  = cpu_write_mask_i;
            end
            OWNER_AUX: begin
                aux_ready_o       = 1'b1;
`ifdef CPU_DMEM_ARB_STARVE_EN
                cpu_stall_o       = cpu_req;
`endif
                mem_addr_o        = aux_addr_w;
                mem_read_enable_o = ~aux_write_i;
                mem_write_data_o  = aux_write_data_i;
                mem_write_mask_o  = aux_write_i ? aux_write_mask_i : 4'b0000;
            end
            default: ;
        endcase
    end

    assign aux_hs       = aux_valid_i & aux_ready_o;
    assign aux_rvalid_d = aux_hs & ~aux_write_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            aux_rvalid_q <= 1'b0;
        end else begin
            aux_rvalid_q <= aux_rvalid_d;
        end
    end

    assign aux_rvalid_o = aux_rvalid_q;
    assign aux_rdata_o  = aux_rvalid_q ? mem_read_data_i : '0;

endmodule

// File: tb/tb_cpu_dmem_arb.sv
// Randomised scoreboard bench for cpu_dmem_arb with a behavioural memory and
// arbitration model; follows CPU_DMEM_ARB_STARVE_EN like the design.
module tb_cpu_dmem_arb;

    localparam int unsigned LIMIT = 4;

    typedef struct {
        bit          v;
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } aux_req_t;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [31:0] cpu_addr_i;
    logic        cpu_read_enable_i;
    logic [31:0] cpu_write_data_i;
    logic [3:0]  cpu_write_mask_i;
    logic        cpu_stall_o;
    logic        aux_valid_i;
    logic        aux_ready_o;
    logic [31:0] aux_addr_i;
    logic        aux_write_i;
    logic [31:0] aux_write_data_i;
    logic [3:0]  aux_write_mask_i;
    logic [31:0] aux_rdata_o;
    logic        aux_rvalid_o;
    logic [31:0] mem_addr_o;
    logic        mem_read_enable_o;
    logic [31:0] mem_write_data_o;
    logic [3:0]  mem_write_mask_o;
    logic [31:0] mem_read_data_i;

    cpu_dmem_arb #(
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .cpu_addr_i       (cpu_addr_i),
        .cpu_read_enable_i(cpu_read_enable_i),
        .cpu_write_data_i (cpu_write_data_i),
        .cpu_write_mask_i (cpu_write_mask_i),
        .cpu_stall_o      (cpu_stall_o),
        .aux_valid_i      (aux_valid_i),
        .aux_ready_o      (aux_ready_o),
        .aux_addr_i       (aux_addr_i),
        .aux_write_i      (aux_write_i),
        .aux_write_data_i (aux_write_data_i),
        .aux_write_mask_i (aux_write_mask_i),
        .aux_rdata_o      (aux_rdata_o),
        .aux_rvalid_o     (aux_rvalid_o),
        .mem_addr_o       (mem_addr_o),
        .mem_read_enable_o(mem_read_enable_o),
        .mem_write_data_o (mem_write_data_o),
        .mem_write_mask_o (mem_write_mask_o),
        .mem_read_data_i  (mem_read_data_i)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] dev_mem [256];
    logic [31:0] ref_mem [256];
    aux_req_t    aux_q [$];
    logic [31:0] exp_q [$];
    bit          aux_hs = 1'b0;
    bit          m_rv_pend = 1'b0;
`ifdef CPU_DMEM_ARB_STARVE_EN
    int unsigned m_wait = 0;
`endif
    int          cpu_mode = 0;
    logic        rst_val = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic ref_write(input int unsigned idx, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    // Synchronous memory: read data one cycle after the address, garbage otherwise.
    always @(posedge clk) begin
        if (mem_read_enable_o) mem_read_data_i <= dev_mem[mem_addr_o[9:2]];
        else                   mem_read_data_i <= $urandom;
        for (int b = 0; b < 4; b++)
            if (mem_write_mask_o[b]) dev_mem[mem_addr_o[9:2]][8*b +: 8] = mem_write_data_o[8*b +: 8];
    end

    // Reference model and monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        logic        creq, forced, cpu_win, aux_win;
        logic        e_ready, e_stall, e_re, e_rvalid;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_mask;
        aux_hs   = aux_valid_i && aux_ready_o;
        e_ready  = 1'b0; e_stall = 1'b0; e_re = 1'b0; e_rvalid = 1'b0;
        e_addr   = '0;   e_wd    = '0;   e_mask = '0;
        if (!reset_ni) begin
            m_rv_pend = 1'b0;
            exp_q.delete();
`ifdef CPU_DMEM_ARB_STARVE_EN
            m_wait = 0;
`endif
        end else begin
            e_rvalid = m_rv_pend;
            creq = cpu_read_enable_i || (cpu_write_mask_i != 4'b0000);
`ifdef CPU_DMEM_ARB_STARVE_EN
            forced = aux_valid_i && (m_wait >= LIMIT);
`else
            forced = 1'b0;
`endif
            cpu_win = creq && !forced;
            aux_win = aux_valid_i && !cpu_win;
            e_ready = aux_win;
            e_stall = creq && !cpu_win;
            if (cpu_win) begin
                e_addr = cpu_addr_i; e_re = cpu_read_enable_i;
                e_wd   = cpu_write_data_i; e_mask = cpu_write_mask_i;
            end else if (aux_win) begin
                e_addr = (aux_addr_i / 4) * 4; e_re = !aux_write_i;
                e_wd   = aux_write_data_i; e_mask = aux_write_i ? aux_write_mask_i : 4'b0000;
            end
            m_rv_pend = 1'b0;
            if (aux_win && !aux_write_i) begin
                exp_q.push_back(ref_mem[e_addr[9:2]]);
                m_rv_pend = 1'b1;
            end
`ifdef CPU_DMEM_ARB_STARVE_EN
            if (aux_win) m_wait = 0;
            else if (aux_valid_i && m_wait < LIMIT) m_wait++;
`endif
            if (e_mask != 4'b0000) ref_write(e_addr[9:2], e_wd, e_mask);
        end
        chk("aux_ready", 32'(aux_ready_o), 32'(e_ready));
        chk("cpu_stall", 32'(cpu_stall_o), 32'(e_stall));
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_read_enable", 32'(mem_read_enable_o), 32'(e_re));
        chk("mem_write_data", mem_write_data_o, e_wd);
        chk("mem_write_mask", 32'(mem_write_mask_o), 32'(e_mask));
        chk("aux_rvalid", 32'(aux_rvalid_o), 32'(e_rvalid));
        if (aux_rvalid_o) begin
            if (exp_q.size() == 0) chk("aux_rdata_orphan", 32'(exp_q.size()), 32'd1);
            else                   chk("aux_rdata", aux_rdata_o, exp_q.pop_front());
        end else begin
            chk("aux_rdata_idle", aux_rdata_o, 32'd0);
        end
    end

    task automatic cycle();
        aux_req_t r;
        int       k;
        @(posedge clk);
        #1;
        reset_ni = rst_val;
        cpu_addr_i       = 32'($urandom_range(0, 255)) << 2;
        cpu_write_data_i = $urandom;
        cpu_read_enable_i = 1'b0;
        cpu_write_mask_i  = 4'b0000;
        case (cpu_mode)
            1: cpu_read_enable_i = 1'b1;
            2: begin
                k = int'($urandom_range(0, 9));
                if (k >= 7)      cpu_write_mask_i = 4'($urandom_range(1, 15));
                else if (k >= 4) cpu_read_enable_i = 1'b1;
            end
            3: begin
                cpu_addr_i = 32'h40; cpu_write_mask_i = 4'b0011;
                cpu_write_data_i = 32'h0000_1234;
            end
            default: ;
        endcase
        if (!(aux_valid_i && !aux_hs)) begin
            if (aux_q.size() > 0) begin
                r = aux_q.pop_front();
                aux_valid_i = r.v; aux_write_i = r.w; aux_addr_i = r.addr;
                aux_write_data_i = r.data; aux_write_mask_i = r.mask;
            end else begin
                aux_valid_i = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic push_aux(input bit v, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        aux_req_t r;
        r.v = v; r.w = w; r.addr = a; r.data = d; r.mask = m;
        aux_q.push_back(r);
    endtask

    initial begin
        logic [31:0] v;
        reset_ni = 1'b0;
        cpu_addr_i = '0; cpu_read_enable_i = 1'b0; cpu_write_data_i = '0; cpu_write_mask_i = '0;
        aux_valid_i = 1'b0; aux_addr_i = '0; aux_write_i = 1'b0;
        aux_write_data_i = '0; aux_write_mask_i = '0; mem_read_data_i = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom; dev_mem[i] = v; ref_mem[i] = v;
        end
        dev_mem[64] = 32'hDEAD_BEEF; ref_mem[64] = 32'hDEAD_BEEF;

        rst_val = 1'b0; run(3);
        rst_val = 1'b1; run(2);

        push_aux(1, 0, 32'h100, 32'h0, 4'h0);
        run(4);

        push_aux(1, 1, 32'h80, 32'hCAFE_F00D, 4'hF);
        cpu_mode = 3; run(2);
        cpu_mode = 0; run(3);

        for (int i = 0; i < 25; i++) push_aux(1, 0, 32'($urandom_range(0, 1023)), 32'h0, 4'h0);
        cpu_mode = 1; run(100);
        cpu_mode = 0; run(30);

        push_aux(1, 0, 32'h100, 32'h0, 4'h0);
        run(1);
        rst_val = 1'b0; cpu_mode = 1; run(3);
        rst_val = 1'b1; cpu_mode = 0; run(3);

        push_aux(1, 0, 32'h0, 32'h0, 4'h0);
        push_aux(1, 0, 32'h4, 32'h0, 4'h0);
        push_aux(1, 0, 32'h8, 32'h0, 4'h0);
        run(6);

        for (int i = 0; i < 1500; i++)
            push_aux($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 1023)), $urandom, 4'($urandom_range(0, 15)));
        cpu_mode = 2;
        for (int i = 0; i < 6000 && aux_q.size() > 0; i++) cycle();
        chk("aux_queue_drained", 32'(aux_q.size()), 32'd0);
        cpu_mode = 0; run(5);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_dmem_arb.md
# cpu_dmem_arb

Shares the single synchronous data-memory port between the CPU memory-access stage and an auxiliary bus master, such as a debug or DMA engine. The CPU normally has fixed priority. A starvation counter forces one auxiliary access through, stalling the CPU for that cycle. The block also tracks in-flight auxiliary reads so that their one-cycle-latency read data returns to the auxiliary master with a valid pulse. It sits between the MA stage's dmem outputs and the data memory.

## Interface
- STARVE_LIMIT, 8, number of consecutive refused auxiliary cycles before an auxiliary access is forced; legal range 1..255; elaboration error otherwise.
- clk_i  in  1  clock.
- reset_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- cpu_addr_i  in  32  CPU word-aligned address, bits [1:0] are zero.
- cpu_read_enable_i  in  1  CPU load.
- cpu_write_data_i  in  32  CPU lane-shifted store data.
- cpu_write_mask_i  in  4  CPU byte write mask.
- cpu_stall_o  out  1  CPU request not serviced this cycle; MA stage must hold.
- aux_valid_i  in  1  auxiliary request valid.
- aux_ready_o  out  1  auxiliary request accepted this cycle.
- aux_addr_i  in  32  auxiliary word address; bits [1:0] are ignored and forced to 0.
- aux_write_i  in  1  1 = store, 0 = load.
- aux_write_data_i  in  32  auxiliary store data.
- aux_write_mask_i  in  4  auxiliary byte mask; ignored for loads.
- aux_rdata_o  out  32  auxiliary load data; 0 when aux_rvalid_o is low.
- aux_rvalid_o  out  1  auxiliary load data valid.
- mem_addr_o  out  32  memory address.
- mem_read_enable_o  out  1  memory read enable.
- mem_write_data_o  out  32  memory write data.
- mem_write_mask_o  out  4  memory byte write enable.
- mem_read_data_i  in  32  memory read data, valid one cycle after the address.

## Operation
- A CPU request is active when cpu_read_enable_i is high or any bit of cpu_write_mask_i is set.
- The grant is combinational, from the current inputs and the registered state:
  - Forced auxiliary grant: force_r is set and aux_valid_i is high. The auxiliary master is granted and cpu_stall_o equals cpu_req.
  - Otherwise, if a CPU request is active, the CPU is granted and aux_ready_o is 0.
  - Otherwise, if aux_valid_i is high, the auxiliary master is granted.
  - Otherwise the port is idle: all mem_* outputs are 0.
- The granted requester's fields drive mem_*.
  - For the auxiliary master: mem_read_enable_o = !aux_write_i; mem_write_mask_o = aux_write_i ? aux_write_mask_i : 4'b0.
- Starvation counter wait_r, 8 bits:
  - Increments, saturating at STARVE_LIMIT, on each cycle with aux_valid_i high and aux_ready_o low.
  - Clears on each auxiliary handshake (aux_valid_i and aux_ready_o both high).
- force_r is registered: it is set when the next value of wait_r equals STARVE_LIMIT, and cleared on an auxiliary handshake.
- Read tracking: aux_rvalid_r is set on the cycle after an accepted auxiliary load and is 0 otherwise.
- aux_rdata_o = aux_rvalid_r ? mem_read_data_i : 0.
- The auxiliary master must hold all request fields stable while aux_valid_i is high and aux_ready_o is low.

## Timing
- Grant and stall are zero-latency (combinational).
- Auxiliary read data is presented in the cycle after acceptance. Back-to-back auxiliary loads produce back-to-back rvalid pulses.
- Reset, and any cycle while reset_ni is low:
  - wait_r = 0, force_r = 0, aux_rvalid_r = 0.
  - aux_ready_o = 0, cpu_stall_o = 0, all mem_* = 0.
- Reset asserted mid-read: the pending rvalid is dropped and no pulse follows.
- Forced grant while the CPU is idle is an ordinary grant. No stall occurs and force_r clears.
- force_r set while aux_valid_i is low: no effect. The CPU keeps priority until the auxiliary master is valid again.
- A CPU stall lasts exactly one cycle per forced grant. The CPU must then win for at least the next cycle, because wait_r restarts from 0.
- STARVE_LIMIT = 1: a refused auxiliary cycle forces a grant on the next cycle, so the worst case is CPU/auxiliary alternation.

## Configuration
- CPU_DMEM_ARB_STARVE_EN defined: starvation counter and forced grant behave as described above.
- CPU_DMEM_ARB_STARVE_EN undefined:
  - wait_r and force_r are removed and cpu_stall_o is tied to 0.
  - The CPU has strict priority; the auxiliary master may starve indefinitely.
  - STARVE_LIMIT is ignored.

## Structure
- cpu_common gains:
  - the enum dmem_owner_t (OWNER_NONE, OWNER_CPU, OWNER_AUX);
  - DMEM_ARB_LIMIT_DEFAULT = 8.
- word_t comes from common.
- Sub-module cpu_dmem_starve_ctr holds wait_r and force_r. It is instantiated only under CPU_DMEM_ARB_STARVE_EN.

## Test plan
- Auxiliary load only, with aux_addr_i = 0x100 and memory word 0x100 = 0xDEADBEEF:
  - aux_ready_o is 1 in the same cycle;
  - in the next cycle aux_rvalid_o = 1 and aux_rdata_o = 0xDEADBEEF.
- CPU store (mask 4'b0011, address 0x40) concurrent with an auxiliary store to 0x80:
  - mem_addr_o = 0x40 and cpu_stall_o = 0;
  - the auxiliary master is accepted on the first CPU-idle cycle, with mem_addr_o = 0x80.
- STARVE_LIMIT = 4, continuous CPU loads, aux_valid_i held high from cycle 0:
  - aux_ready_o is low for cycles 0–3;
  - in cycle 4, aux_ready_o = 1 and cpu_stall_o = 1;
  - in cycle 5 the CPU is granted again;
  - the pattern repeats every 5 cycles.
- Macro undefined, same stimulus as the previous case: aux_ready_o never rises and cpu_stall_o stays 0 for 100 cycles.
- Reset asserted in the cycle after an auxiliary load is accepted:
  - aux_rvalid_o = 0 immediately;
  - no pulse follows after reset_ni rises;
  - all outputs are 0 while reset is held.
- Three back-to-back auxiliary loads (0x0, 0x4, 0x8) with the CPU idle: aux_rvalid_o is high for 3 consecutive cycles, returning the three words in order.
